// File: rtl/sb_pkg.sv
// Shared definitions for the sideband TX serializer: FSM state encoding
// and default framing/pattern geometry.
package sb_pkg;

  localparam int SB_PKT_W    = 64;
  localparam int SB_GAP_UI   = 32;
  localparam int SB_PAT_UI   = 64;
  localparam int SB_PAT_ITER = 4;

  typedef enum logic [2:0] {
    SB_IDLE    = 3'd0,
    SB_PATTERN = 3'd1,
    SB_HDR     = 3'd2,
    SB_DATA    = 3'd3,
    SB_GAP     = 3'd4
  } sb_ser_state_e;

endpackage

// File: rtl/sb_tx_shift_reg.sv
// Load/shift-right register feeding the sideband lane LSB first; shared by
// header, data word and pattern toggles.
module sb_tx_shift_reg
  import sb_pkg::*;
#(
  parameter int W = SB_PKT_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] load_val,
  output logic         bit0
);

  logic [W-1:0] sr_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= load_val;
    end else if (shift) begin
      sr_q <= {1'b0, sr_q[W-1:1]};
    end
  end

  // Zero fill means the lane naturally idles low once a word is exhausted.
  assign bit0 = sr_q[0];

endmodule

// File: rtl/sb_tx_serializer.sv
// Sideband TX back end: serializes header/data packets with a mandatory idle
// gap and generates the start/init toggle pattern with a done pulse.
module sb_tx_serializer
  import sb_pkg::*;
#(
  parameter int PKT_W    = SB_PKT_W,
  parameter int GAP_UI   = SB_GAP_UI,
  parameter int PAT_UI   = SB_PAT_UI,
  parameter int PAT_ITER = SB_PAT_ITER
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pattern_req,
  input  logic             i_pattern_stop,
  input  logic             i_pkt_valid,
  input  logic             i_has_data,
  input  logic [PKT_W-1:0] i_header,
  input  logic [PKT_W-1:0] i_data,
  output logic             o_pkt_ready,
  output logic             o_txdata_sb,
  output logic             o_txclk_en,
  output logic             o_pattern_done,
  output logic             o_busy
);

  localparam int UI_W   = 7;
  localparam int ITER_W = $clog2(PAT_ITER + 1);

  localparam logic [UI_W-1:0]   WORD_LAST = UI_W'(PKT_W - 1);
  localparam logic [UI_W-1:0]   GAP_LAST  = UI_W'(GAP_UI - 1);
  localparam logic [UI_W-1:0]   PAT_TOG   = UI_W'(PAT_UI);
  localparam logic [UI_W-1:0]   PAT_LAST  = UI_W'(PAT_UI + GAP_UI - 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(PAT_ITER - 1);
  localparam logic [PKT_W-1:0]  PAT_WORD  = {(PKT_W / 2){2'b01}};

  sb_ser_state_e     state_q, state_d;
  logic [UI_W-1:0]   ui_q, ui_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              stop_q, stop_d;
  logic              has_data_q;
  logic [PKT_W-1:0]  data_q;

  logic              accept;
  logic              done_d;
  logic              sr_load, sr_shift;
  logic [PKT_W-1:0]  sr_val;

  // NOTE: every always_comb output gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    ui_d     = ui_q + UI_W'(1);
    iter_d   = iter_q;
    stop_d   = stop_q;
    accept   = 1'b0;
    done_d   = 1'b0;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    sr_val   = '0;

    unique case (state_q)
      SB_IDLE: begin
        ui_d = '0;
        if (i_pattern_req) begin
          state_d = SB_PATTERN;
          iter_d  = '0;
          stop_d  = 1'b0;
          sr_load = 1'b1;
          sr_val  = PAT_WORD;
        end else if (i_pkt_valid && o_pkt_ready) begin
          accept  = 1'b1;
          state_d = SB_HDR;
          sr_load = 1'b1;
          sr_val  = i_header;
        end
      end
      SB_HDR: begin
        sr_shift = 1'b1;
        if (ui_q == WORD_LAST) begin
          if (has_data_q) begin
            state_d = SB_DATA;
            sr_load = 1'b1;
            sr_val  = data_q;
          end else begin
            state_d = SB_GAP;
          end
        end
      end
      SB_DATA: begin
        sr_shift = 1'b1;
        if (ui_q == WORD_LAST) state_d = SB_GAP;
      end
      SB_GAP: begin
        sr_shift = 1'b1;
        if (ui_q == GAP_LAST) state_d = SB_IDLE;
      end
      SB_PATTERN: begin
        sr_shift = 1'b1;
        if (i_pattern_stop) stop_d = 1'b1;
        // Iteration boundary: finish the burst or rearm the toggle word.
        if (ui_q == PAT_LAST) begin
          if (iter_q == ITER_LAST || stop_d) begin
            state_d = SB_IDLE;
            done_d  = 1'b1;
            stop_d  = 1'b0;
          end else begin
            iter_d  = iter_q + ITER_W'(1);
            ui_d    = '0;
            sr_load = 1'b1;
            sr_val  = PAT_WORD;
          end
        end
      end
      default: state_d = SB_IDLE;
    endcase

    if (state_d != state_q) ui_d = '0;
  end

  // NOTE: the latched data word shares the async reset with the control path
  // so nothing from an aborted packet survives a mid-operation reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= SB_IDLE;
      ui_q           <= '0;
      iter_q         <= '0;
      stop_q         <= 1'b0;
      has_data_q     <= 1'b0;
      data_q         <= '0;
      o_pkt_ready    <= 1'b0;
      o_txclk_en     <= 1'b0;
      o_pattern_done <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      state_q        <= state_d;
      ui_q           <= ui_d;
      iter_q         <= iter_d;
      stop_q         <= stop_d;
      if (accept) begin
        has_data_q <= i_has_data;
        data_q     <= i_data;
      end
      // Ready only after a full IDLE cycle, so it never overlaps an accept.
      o_pkt_ready    <= (state_q == SB_IDLE) && (state_d == SB_IDLE) && !i_pattern_req;
      o_txclk_en     <= (state_d == SB_HDR) || (state_d == SB_DATA) ||
                        ((state_d == SB_PATTERN) && (ui_d < PAT_TOG));
      o_pattern_done <= done_d;
      o_busy         <= (state_d != SB_IDLE);
    end
  end

  sb_tx_shift_reg #(.W(PKT_W)) u_shift (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .load     (sr_load),
    .shift    (sr_shift),
    .load_val (sr_val),
    .bit0     (o_txdata_sb)
  );

endmodule

// File: tb/tb_sb_tx_serializer.sv
// Scoreboard bench for sb_tx_serializer: stimulus queues the expected per-cycle
// output vector {txdata, clk_en, busy, ready, done}; a negedge monitor compares.
module tb_sb_tx_serializer;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_pattern_req = 1'b0;
  logic        i_pattern_stop = 1'b0;
  logic        i_pkt_valid = 1'b0;
  logic        i_has_data = 1'b0;
  logic [63:0] i_header = '0;
  logic [63:0] i_data = '0;
  logic        o_pkt_ready, o_txdata_sb, o_txclk_en, o_pattern_done, o_busy;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];
  string      name_q[$];

  sb_tx_serializer dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_pattern_req  (i_pattern_req),
    .i_pattern_stop (i_pattern_stop),
    .i_pkt_valid    (i_pkt_valid),
    .i_has_data     (i_has_data),
    .i_header       (i_header),
    .i_data         (i_data),
    .o_pkt_ready    (o_pkt_ready),
    .o_txdata_sb    (o_txdata_sb),
    .o_txclk_en     (o_txclk_en),
    .o_pattern_done (o_pattern_done),
    .o_busy         (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input string nm, input int k, input logic txd, input logic clk_en,
                      input logic busy, input logic ready, input logic done);
    exp_q.push_back({txd, clk_en, busy, ready, done});
    name_q.push_back($sformatf("%s[%0d]", nm, k));
  endtask

  // Expected lane activity from the cycle after the accept edge.
  task automatic push_pkt(input string nm, input logic [63:0] hdr, input logic has,
                          input logic [63:0] dat);
    int k = 0;
    for (int i = 0; i < 64; i++) begin push(nm, k, hdr[i], 1'b1, 1'b1, 1'b0, 1'b0); k++; end
    if (has) begin
      for (int i = 0; i < 64; i++) begin push(nm, k, dat[i], 1'b1, 1'b1, 1'b0, 1'b0); k++; end
    end
    for (int i = 0; i < 32; i++) begin push(nm, k, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); k++; end
    push(nm, k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); k++;
    push(nm, k, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Expected burst from the cycle after PATTERN entry, then done and ready.
  task automatic push_pattern(input string nm, input int iters);
    int k = 0;
    for (int it = 0; it < iters; it++) begin
      for (int ui = 0; ui < 96; ui++) begin
        if (ui < 64) push(nm, k, (ui % 2 == 0), 1'b1, 1'b1, 1'b0, 1'b0);
        else         push(nm, k, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        k++;
      end
    end
    push(nm, k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); k++;
    push(nm, k, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  always @(negedge i_clk) begin
    if (exp_q.size() > 0) begin
      logic [4:0] e;
      string      nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check(nm, {59'd0, o_txdata_sb, o_txclk_en, o_busy, o_pkt_ready, o_pattern_done},
            {59'd0, e});
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    check({"drain_", nm}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    name_q.delete();
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_txd"},   64'(o_txdata_sb),    64'd0);
    check({nm, "_clken"}, 64'(o_txclk_en),     64'd0);
    check({nm, "_done"},  64'(o_pattern_done), 64'd0);
    check({nm, "_busy"},  64'(o_busy),         64'd0);
    check({nm, "_ready"}, 64'(o_pkt_ready),    64'd0);
  endtask

  task automatic release_reset(input string nm);
    i_rst_n = 1'b1;
    push(nm, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k < 5; k++) push(nm, k, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_drain(nm);
  endtask

  initial begin
    // Power-on reset.
    tick();
    tick();
    check_all_zero("rst");
    release_reset("post_rst");

    // Header-only packet.
    check("ready_hdr_only", 64'(o_pkt_ready), 64'd1);
    i_pkt_valid = 1'b1;
    i_header    = 64'h0000_0000_0000_0005;
    i_has_data  = 1'b0;
    tick();
    i_pkt_valid = 1'b0;
    i_header    = 64'hDEAD_BEEF_DEAD_BEEF;
    push_pkt("hdr_only", 64'h0000_0000_0000_0005, 1'b0, 64'd0);
    wait_drain("hdr_only");

    // Header + data packet; bus changes after accept must be ignored.
    check("ready_hdr_data", 64'(o_pkt_ready), 64'd1);
    i_pkt_valid = 1'b1;
    i_header    = 64'h8000_0000_0000_0001;
    i_data      = 64'hFFFF_FFFF_FFFF_FFFF;
    i_has_data  = 1'b1;
    tick();
    i_pkt_valid = 1'b0;
    i_data      = 64'd0;
    i_has_data  = 1'b0;
    push_pkt("hdr_data", 64'h8000_0000_0000_0001, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_drain("hdr_data");

    // Full pattern burst; request drops mid-burst with no effect.
    check("ready_pat", 64'(o_pkt_ready), 64'd1);
    i_pattern_req = 1'b1;
    tick();
    i_pattern_req = 1'b0;
    push_pattern("pat4", 4);
    wait_drain("pat4");

    // Early stop in cycle 10 of the first iteration.
    i_pattern_req = 1'b1;
    tick();
    i_pattern_req = 1'b0;
    push_pattern("pat_stop", 1);
    repeat (9) tick();
    i_pattern_stop = 1'b1;
    tick();
    i_pattern_stop = 1'b0;
    wait_drain("pat_stop");

    // Pattern request beats a simultaneous packet; packet goes after done.
    i_pattern_req = 1'b1;
    i_pkt_valid   = 1'b1;
    i_header      = 64'hA5A5_0000_FFFF_1234;
    i_has_data    = 1'b0;
    tick();
    i_pattern_req = 1'b0;
    push_pattern("race_pat", 1);
    push_pkt("race_pkt", 64'hA5A5_0000_FFFF_1234, 1'b0, 64'd0);
    repeat (4) tick();
    i_pattern_stop = 1'b1;
    tick();
    i_pattern_stop = 1'b0;
    repeat (93) tick();
    i_pkt_valid = 1'b0;
    i_header    = 64'hFFFF_FFFF_FFFF_FFFF;
    i_has_data  = 1'b1;
    wait_drain("race");

    // Reset asserted while header bit 30 is on the lane.
    check("ready_rst_mid", 64'(o_pkt_ready), 64'd1);
    i_pkt_valid = 1'b1;
    i_header    = 64'hFFFF_FFFF_FFFF_FFFF;
    i_has_data  = 1'b1;
    i_data      = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    i_pkt_valid = 1'b0;
    for (int k = 0; k < 30; k++) push("pre_rst", k, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (30) tick();
    check("pre_rst_queue", 64'(exp_q.size()), 64'd0);
    i_rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    tick();
    tick();
    check_all_zero("rst_hold");
    release_reset("post_rst_mid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sb_tx_serializer.md
Name: sb_tx_serializer

Overview:
- Sideband TX back end: takes one framed packet (64-bit header plus optional 64-bit data word) from the TX framing stage and shifts it out 1 bit/UI on the sideband data lane, with a gated sideband clock enable.
- Enforces the mandatory 32-UI idle gap after every packet.
- Also generates the sideband start/init pattern on request and reports its completion. This is the source of the start-pattern-done indication consumed by the sideband TX controller.

Parameters:
- PKT_W, 64, bits per header or data word
- GAP_UI, 32, idle UIs after each packet and after each pattern burst
- PAT_UI, 64, UIs of alternating toggle per pattern iteration
- PAT_ITER, 4, pattern iterations run when not stopped early

Ports:
- i_clk  in  1  sideband serial clock, 1 UI per cycle
- i_rst_n  in  1  asynchronous active-low reset
- i_pattern_req  in  1  level; start the pattern burst when in IDLE
- i_pattern_stop  in  1  pulse; end the pattern at the next iteration boundary
- i_pkt_valid  in  1  framed packet available
- i_has_data  in  1  packet carries a data word; qualified by i_pkt_valid
- i_header  in  PKT_W  framed header; sampled on accept
- i_data  in  PKT_W  framed data word; sampled on accept
- o_pkt_ready  out  1  serializer can accept a packet
- o_txdata_sb  out  1  serial sideband data, LSB first
- o_txclk_en  out  1  sideband clock gate enable
- o_pattern_done  out  1  one-cycle pulse at the end of the pattern burst
- o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all state cleared, FSM in IDLE.
  - Outputs: o_txdata_sb=0, o_txclk_en=0, o_pattern_done=0, o_busy=0, o_pkt_ready=0.
  - o_pkt_ready becomes 1 in the first cycle after reset deassertion.
- Reset mid-operation: aborts immediately. No partial packet resumes after reset and no done pulse is produced.
- States: IDLE, PATTERN, HDR, DATA, GAP. All outputs are registered.
- IDLE:
  - o_pkt_ready = ~i_pattern_req.
  - If i_pattern_req=1: go to PATTERN. i_pattern_req wins over i_pkt_valid in the same cycle, and the packet is not accepted.
  - Else if i_pkt_valid=1: accept. Latch i_header into the shift register, latch i_data, latch i_has_data, go to HDR.
  - Only one packet is accepted per IDLE visit.
- HDR:
  - Emits header bit k on o_txdata_sb in the k-th cycle after accept (k=0..63). Bit 0 appears the cycle after the accept edge.
  - o_txclk_en=1.
  - After bit 63: go to DATA if has_data latched, else GAP.
- DATA: same as HDR for the data word, 64 cycles, o_txclk_en=1, then go to GAP.
- GAP:
  - o_txdata_sb=0, o_txclk_en=0 for exactly GAP_UI cycles, then go to IDLE.
  - Back-to-back packets therefore start no sooner than GAP_UI+1 cycles after the previous last bit.
- PATTERN:
  - Each iteration is PAT_UI cycles of o_txdata_sb = 1,0,1,0,… (first bit 1) with o_txclk_en=1, followed by GAP_UI cycles of data 0 and clock-enable 0.
  - An i_pattern_stop pulse at any cycle is latched. The current iteration completes, including its gap.
  - The burst ends after PAT_ITER iterations or at the first iteration boundary after a stop, whichever comes first.
  - At the end, o_pattern_done=1 for one cycle coincident with entry to IDLE, and the stop latch clears.
  - i_pattern_req deasserting mid-burst has no effect.
  - If i_pattern_req is still high in IDLE, a new burst starts.
- Latency and packet length:
  - Header-only packet: accept to IDLE = 64+32 cycles, i.e. o_pkt_ready high again 97 cycles after the accept edge.
  - Header+data packet: 161 cycles.
- Counters:
  - 7-bit UI counter, cleared on every state entry.
  - 3-bit iteration counter (sized clog2(PAT_ITER+1)), cleared on PATTERN entry.
  - No wrap is reachable with default parameters.
- i_header, i_data and i_has_data are ignored outside the accept cycle. Upstream may change them freely once o_pkt_ready is low.

Decomposition:
- Shared package sb_pkg:
  - state enum sb_ser_state_e
  - constants SB_PKT_W=64, SB_GAP_UI=32, SB_PAT_UI=64
- One natural sub-module: sb_tx_shift_reg, a 64-bit load/shift-right register with bit-0 output, instantiated once and reused for header then data (data reloaded at the HDR→DATA boundary).
- FSM and counters stay in the top.

Test Plan:
- Header-only packet: i_header=64'h0000_0000_0000_0005, i_has_data=0 → o_txdata_sb shows 1,0,1,0×60… over 64 cycles with clock-enable 1, then 32 cycles of 0/0, then o_pkt_ready=1 at cycle 97.
- Header+data packet: header 64'h8000_0000_0000_0001, data 64'hFFFF_FFFF_FFFF_FFFF → bit 0=1, bit 63=1, next 64 bits all 1, then a 32-cycle gap; total 161 cycles.
- Pattern, no stop: pulse i_pattern_req → 4×(64 toggles starting with 1 + 32 idle) = 384 cycles, then o_pattern_done pulse exactly once.
- Early stop: i_pattern_stop pulsed at cycle 10 of iteration 1 → burst ends after iteration 1 (96 cycles), done pulse, o_busy=0.
- Simultaneous i_pattern_req and i_pkt_valid in IDLE → PATTERN entered, packet not accepted (o_pkt_ready=0). The packet is accepted on the first IDLE cycle after done with i_pattern_req low.
- Reset asserted at header bit 30 → all outputs 0 asynchronously. After release, the FSM is in IDLE, o_pkt_ready=1, and no residual bits are shifted.
